// File: rtl/alu.sv
// Board-level ALU: operands and opcode are latched from a shared switch bank under
// independent load buttons; the result is driven combinationally onto the LEDs.
module alu #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_bA,
    input  logic               i_bB,
    input  logic               i_bOP,
    input  logic [NB_DATA-1:0] i_Switch,
    output logic [NB_DATA-1:0] o_LEDS
);

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    logic [NB_DATA-1:0] reg_a;
    logic [NB_DATA-1:0] reg_b;
    logic [NB_OP-1:0]   reg_op;

    // Buttons are level-sensitive: a held button simply reloads the same value each edge.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            reg_a  <= '0;
            reg_b  <= '0;
            reg_op <= '0;
        end else begin
            if (i_bA)  reg_a  <= i_Switch;
            if (i_bB)  reg_b  <= i_Switch;
            if (i_bOP) reg_op <= i_Switch[NB_OP-1:0];
        end
    end

    // Shift amount is the full unsigned B, so B >= NB_DATA saturates to all-fill.
    always_comb begin
        o_LEDS = '0;
        case (reg_op)
            OP_ADD:  o_LEDS = reg_a + reg_b;
            OP_SUB:  o_LEDS = reg_a - reg_b;
            OP_AND:  o_LEDS = reg_a & reg_b;
            OP_OR:   o_LEDS = reg_a | reg_b;
            OP_XOR:  o_LEDS = reg_a ^ reg_b;
            OP_NOR:  o_LEDS = ~(reg_a | reg_b);
            OP_SRA:  o_LEDS = $unsigned($signed(reg_a) >>> reg_b);
            OP_SRL:  o_LEDS = reg_a >> reg_b;
            default: o_LEDS = '0;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus randomized button/switch traffic
// compared against an arithmetic reference model.
module tb_alu;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_bA = 1'b0;
    logic       i_bB = 1'b0;
    logic       i_bOP = 1'b0;
    logic [7:0] i_Switch = 8'h00;
    logic [7:0] o_LEDS;

    int checks = 0;
    int errors = 0;

    // Reference state mirrored from the button/switch activity the bench applies.
    int m_a = 0;
    int m_b = 0;
    int m_op = 0;

    alu #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_bA     (i_bA),
        .i_bB     (i_bB),
        .i_bOP    (i_bOP),
        .i_Switch (i_Switch),
        .o_LEDS   (o_LEDS)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        int r;
        int src;
        r = 0;
        case (op)
            32: r = (a + b) % 256;
            34: r = (a - b + 256) % 256;
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            2:  r = (b >= 8) ? 0 : a / (2 ** b);
            3: begin
                for (int i = 0; i < 8; i++) begin
                    src = (i + b < 8) ? ((a / (2 ** (i + b))) % 2) : (a / 128);
                    r = r + src * (2 ** i);
                end
            end
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // Drive one clock edge with the given controls, then update the model.
    task automatic apply(input logic rst_n, input logic ba, input logic bb, input logic bop,
                         input logic [7:0] sw);
        @(negedge i_clock);
        i_reset = rst_n; i_bA = ba; i_bB = bb; i_bOP = bop; i_Switch = sw;
        @(posedge i_clock);
        #1;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0;
        end else begin
            if (ba)  m_a = int'(sw);
            if (bb)  m_b = int'(sw);
            if (bop) m_op = int'(sw[5:0]);
        end
        i_reset = 1'b1; i_bA = 1'b0; i_bB = 1'b0; i_bOP = 1'b0;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'b0010_0000);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL add_zero got=%h exp=00", o_LEDS);
        end
    endtask

    task automatic test_ops();
        logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        logic [7:0] exps[8] = '{8'h0D, 8'h07, 8'h02, 8'h0B, 8'h09, 8'hF4, 8'h01, 8'h01};
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h0A);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, ops[i]);
            checks++;
            if (o_LEDS !== exps[i] || o_LEDS !== ref_alu(m_a, m_b, m_op)) begin
                errors++;
                $display("FAIL op_%h got=%h exp=%h", ops[i], o_LEDS, exps[i]);
            end
        end
        // op is SRL now; reload A with a negative value
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'hFB);
        checks++;
        if (o_LEDS !== 8'h1F) begin
            errors++;
            $display("FAIL srl_fb got=%h exp=1f", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
        checks++;
        if (o_LEDS !== 8'hFF) begin
            errors++;
            $display("FAIL sra_fb got=%h exp=ff", o_LEDS);
        end
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL add_wrap got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h22);
        checks++;
        if (o_LEDS !== 8'hFF) begin
            errors++;
            $display("FAIL sub_wrap got=%h exp=ff", o_LEDS);
        end
    endtask

    task automatic test_undefined_and_shift_limits();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h09);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL op_000000 got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h3F);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL op_111111 got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL srl_b9 got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
        checks++;
        if (o_LEDS !== 8'hFF) begin
            errors++;
            $display("FAIL sra_b9 got=%h exp=ff", o_LEDS);
        end
        // upper switch bits are ignored by the opcode register
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'hE0);
        checks++;
        if (o_LEDS !== 8'h89) begin
            errors++;
            $display("FAIL op_upper_bits got=%h exp=89", o_LEDS);
        end
    endtask

    task automatic test_combined_buttons();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h05);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
        checks++;
        if (o_LEDS !== 8'h0A) begin
            errors++;
            $display("FAIL ab_together got=%h exp=0a", o_LEDS);
        end
        // held button reloads idempotently
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        checks++;
        if (o_LEDS !== 8'h0A) begin
            errors++;
            $display("FAIL held_button got=%h exp=0a", o_LEDS);
        end
    endtask

    task automatic test_switch_no_effect();
        logic [7:0] held;
        held = o_LEDS;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom));
            checks++;
            if (o_LEDS !== 8'h0A) begin
                errors++;
                $display("FAIL switch_idle_%0d got=%h exp=0a (was %h)", i, o_LEDS, held);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] valid_ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        logic [7:0] sw;
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom_range(0, 15));
            else sw = 8'($urandom);
            if (($urandom_range(0, 3) != 0) && sel == 4) sw = valid_ops[$urandom_range(0, 7)];
            apply(($urandom_range(0, 49) != 0), sel[0], sel[1], sel[2], sw);
            checks++;
            if (o_LEDS !== ref_alu(m_a, m_b, m_op)) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h op=%h got=%h exp=%h", i,
                         m_a[7:0], m_b[7:0], m_op[5:0], o_LEDS, ref_alu(m_a, m_b, m_op));
            end
        end
    endtask

    task automatic test_mid_reset();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
        checks++;
        if (o_LEDS !== 8'h44) begin
            errors++;
            $display("FAIL pre_reset got=%h exp=44", o_LEDS);
        end
        // reset wins over simultaneously pressed buttons
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h20);
        checks++;
        if (o_LEDS !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=00", o_LEDS);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 8'h27);
        checks++;
        if (o_LEDS !== 8'hFF) begin
            errors++;
            $display("FAIL post_reset_nor got=%h exp=ff", o_LEDS);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_wrap();
        test_undefined_and_shift_limits();
        test_combined_buttons();
        test_switch_no_effect();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
